blink_seq_ctrl: RTL and testbench
=================================

# blink_seq_ctrl

Pattern sequencer that owns the register bus of the 4-channel LED blink peripheral and reprograms its four interval registers from a host-loaded step table. The sequencer dwells on each step for a programmable number of milliseconds, then advances, optionally looping. It sits between the host memory-mapped slot and the blink peripheral, and is the only master on the peripheral's bus.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz. Sets the 1 ms tick period to `CLK_FREQ/1000` cycles, which must be ≥1.
- `STEPS`, 8: table depth. Power of two, 2..8.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cs` in 1: host slot select.
- `we` in 1: host write strobe, qualified by `cs`.
- `rd` in 1: host read strobe, qualified by `cs`.
- `addr` in 6: host word address.
- `wr_data` in 16: host write data.
- `rd_data` out 16: host read data.
- `m_cs` out 1: peripheral select.
- `m_we` out 1: peripheral write strobe.
- `m_addr` out 2: peripheral interval index.
- `m_wr_data` out 16: interval value sent to the peripheral.
- `busy` out 1: high whenever the FSM is not IDLE.
- `irq` out 1: completion interrupt. Level-sensitive. See Configuration.

## Operation
- Host map:
  - 0x00..(4·STEPS−1) TABLE[step·4+led], 16-bit interval.
  - 0x20 CTRL: [0] run, [1] loop, [6:4] last_step.
  - 0x21 DWELL: 16-bit ms.
  - 0x22 STATUS: [0] busy, [3:1] cur_step, [4] done. Writing 1 to bit 4 clears done.
- Unmapped addresses: writes are ignored, reads return 0.
- last_step > STEPS−1 is clamped to STEPS−1.
- DWELL=0 behaves as DWELL=1.
- FSM states: IDLE, LOAD, DWELL.
- **IDLE → LOAD**: occurs when run is 0→1 by a host write. cur_step←0, done←0.
- **LOAD**: issues 4 peripheral writes on consecutive cycles, led index 0,1,2,3.
  - Each cycle: m_cs=m_we=1, m_addr=led, m_wr_data=TABLE[cur_step·4+led].
  - After led 3 the FSM goes to DWELL.
- **DWELL**: counts DWELL ms ticks. On expiry:
  - If cur_step<last_step: cur_step+1, go to LOAD.
  - Else if loop=1: cur_step←0, go to LOAD.
  - Else: run←0, done←1, go to IDLE.
- Writing run=0 in any state aborts to IDLE on the next edge.
  - No further peripheral writes are issued.
  - Intervals already written stay in the peripheral.
  - done is not set.
- Writing run=1 while already running does not restart the sequence. Loop and last_step take effect at the next evaluation.
- Table writes during a run are permitted. They take effect the next time that step is loaded. A write to the entry being sent in the same cycle sends the old value.
- Outside LOAD: m_cs=m_we=0, m_addr=0, m_wr_data=0.

## Timing
- Reset values:
  - All outputs are 0.
  - Table, CTRL, DWELL, done and cur_step are 0.
  - FSM is IDLE.
- Host writes are registered. Host reads are combinational: rd_data is valid in the same cycle as cs&rd, and is 0 otherwise.
- A run write on cycle N gives:
  - LOAD on N+1..N+4.
  - DWELL from N+5.
  - busy high from N+1.
- DWELL lasts exactly DWELL·(CLK_FREQ/1000) cycles. The prescaler is cleared on entry to DWELL.
- Loop wrap and step advance add no idle cycle: LOAD starts on the cycle after DWELL expiry.
- done and busy update on the same edge as the DWELL→IDLE transition.
- An asynchronous rst mid-LOAD deasserts m_cs immediately.

## Configuration
- `BLINK_SEQ_IRQ_EN` defined:
  - irq goes high on the cycle done is set.
  - irq holds until cleared by a STATUS write with bit 4 = 1.
  - CTRL[7] is irq_enable. When it is 0, irq is masked but done is still set.
- `BLINK_SEQ_IRQ_EN` undefined:
  - irq is tied to 0.
  - CTRL[7] reads 0 and ignores writes.
  - done behaves identically.

## Structure
- `blink_seq_pkg` holds:
  - The state enum.
  - Register address constants.
  - CTRL and STATUS bit positions.
  - The `ms_ticks(CLK_FREQ)` function.
- One sub-module, `ms_tick_gen`: the prescaler. It has a clear input and emits a 1-cycle tick every ms.

## Test plan
All scenarios use CLK_FREQ=10_000 (10 cycles per ms) and STEPS=8.
- Reset: assert rst mid-run → all outputs 0 immediately, STATUS reads 0x0000.
- Single step: TABLE[0..3]=0x11,0x22,0x33,0x44, DWELL=2, CTRL=0x0001 → 4 writes to m_addr 0..3 with those values on N+1..N+4, then busy stays high for 20 cycles, then done=1 and busy=0.
- Multi-step loop: last_step=2, loop=1, DWELL=1 → step sequence 0,1,2,0,1… with 10 DWELL cycles between write bursts and no gap at wrap. Clear run mid-DWELL → IDLE next cycle, done=0.
- Abort mid-LOAD: clear run on the cycle m_addr=1 → no write to m_addr 2 or 3, busy low next cycle.
- Boundaries:
  - DWELL=0 → dwell of 10 cycles.
  - last_step=7 with STEPS=4 → clamped to 3.
  - Write to 0x23 → ignored, reads back 0.
  - Re-writing run=1 while running → no restart.
- IRQ (macro defined): CTRL=0x0081, sequence completes → irq=1. Write STATUS=0x0010 → irq=0 and done=0. With CTRL[7]=0 → irq stays 0 while done=1.

Source files
------------

// File: rtl/blink_seq_pkg.sv
// Shared types, register map and helpers for the blink pattern sequencer.
package blink_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DWELL = 2'd2
    } state_e;

    localparam int unsigned LEDS = 4;

    localparam logic [5:0] ADDR_CTRL   = 6'h20;
    localparam logic [5:0] ADDR_DWELL  = 6'h21;
    localparam logic [5:0] ADDR_STATUS = 6'h22;

    localparam int unsigned CTRL_RUN      = 0;
    localparam int unsigned CTRL_LOOP     = 1;
    localparam int unsigned CTRL_LAST_LSB = 4;
    localparam int unsigned CTRL_IRQ_EN   = 7;

    localparam int unsigned STAT_BUSY     = 0;
    localparam int unsigned STAT_STEP_LSB = 1;
    localparam int unsigned STAT_DONE     = 4;

    function automatic int unsigned ms_ticks(input int unsigned clk_freq);
        return clk_freq / 1000;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every TICKS cycles, restarted by clr_i.
module ms_tick_gen #(
    parameter int unsigned TICKS = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/blink_seq_ctrl.sv
// Step-table sequencer driving the 4-channel blink peripheral's interval registers.
// Optional completion interrupt enabled by defining BLINK_SEQ_IRQ_EN.
module blink_seq_ctrl
    import blink_seq_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned STEPS    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic        rd,
    input  logic [5:0]  addr,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_data,
    output logic        m_cs,
    output logic        m_we,
    output logic [1:0]  m_addr,
    output logic [15:0] m_wr_data,
    output logic        busy,
    output logic        irq
);
    localparam int unsigned SW      = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int unsigned TW      = SW + 2;
    localparam int unsigned ENTRIES = STEPS * LEDS;
    localparam int unsigned TICKS   = ms_ticks(CLK_FREQ);
    localparam logic [2:0]  LAST_MAX = 3'(STEPS - 1);

    state_e          state_q, state_d;
    logic [1:0]      led_q, led_d;
    logic [SW-1:0]   step_q, step_d;
    logic [15:0]     ms_cnt_q, ms_cnt_d;
    logic            run_q, run_d;
    logic            loop_q, loop_d;
    logic [2:0]      last_q, last_d;
    logic [15:0]     dwell_q, dwell_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            m_cs_q, m_cs_d;
    logic [1:0]      m_addr_q, m_addr_d;
    logic [15:0]     m_wr_data_q, m_wr_data_d;
    logic [15:0]     tbl_q [ENTRIES];
`ifdef BLINK_SEQ_IRQ_EN
    logic            irq_en_q, irq_en_d;
    logic            irq_q, irq_d;
`endif

    logic        host_wr, tbl_wr, ctrl_wr, dwell_wr, stat_wr;
    logic        start, abort, tick;
    logic [2:0]  last_wr;
    logic [15:0] dwell_last;

    assign host_wr  = cs && we;
    assign tbl_wr   = host_wr && (addr < 6'(ENTRIES));
    assign ctrl_wr  = host_wr && (addr == ADDR_CTRL);
    assign dwell_wr = host_wr && (addr == ADDR_DWELL);
    assign stat_wr  = host_wr && (addr == ADDR_STATUS);
    assign start    = ctrl_wr && wr_data[CTRL_RUN] && !run_q;
    assign abort    = ctrl_wr && !wr_data[CTRL_RUN];
    assign last_wr  = (wr_data[CTRL_LAST_LSB +: 3] > LAST_MAX) ? LAST_MAX
                                                               : wr_data[CTRL_LAST_LSB +: 3];
    // A programmed dwell of 0 ms is treated as 1 ms
    assign dwell_last = (dwell_q == 16'd0) ? 16'd0 : dwell_q - 16'd1;

    ms_tick_gen #(.TICKS(TICKS)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q != S_DWELL),
        .tick_o (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tbl_q[i] <= '0;
            end
        end else if (tbl_wr) begin
            tbl_q[addr[TW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        led_d    = led_q;
        step_d   = step_q;
        ms_cnt_d = ms_cnt_q;
        run_d    = run_q;
        loop_d   = loop_q;
        last_d   = last_q;
        dwell_d  = dwell_q;
        done_d   = done_q;
`ifdef BLINK_SEQ_IRQ_EN
        irq_en_d = irq_en_q;
        irq_d    = irq_q;
`endif

        if (ctrl_wr) begin
            run_d  = wr_data[CTRL_RUN];
            loop_d = wr_data[CTRL_LOOP];
            last_d = last_wr;
`ifdef BLINK_SEQ_IRQ_EN
            irq_en_d = wr_data[CTRL_IRQ_EN];
`endif
        end
        if (dwell_wr) begin
            dwell_d = wr_data;
        end
        if (stat_wr && wr_data[STAT_DONE]) begin
            done_d = 1'b0;
`ifdef BLINK_SEQ_IRQ_EN
            irq_d  = 1'b0;
`endif
        end

        // Abort beats any same-cycle expiry so done is never set by it
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_LOAD;
                        led_d   = 2'd0;
                        step_d  = '0;
                        done_d  = 1'b0;
                    end
                end
                S_LOAD: begin
                    led_d = led_q + 2'd1;
                    if (led_q == 2'd3) begin
                        state_d  = S_DWELL;
                        ms_cnt_d = '0;
                    end
                end
                S_DWELL: begin
                    if (tick) begin
                        if (ms_cnt_q == dwell_last) begin
                            ms_cnt_d = '0;
                            led_d    = 2'd0;
                            if (3'(step_q) < last_q) begin
                                step_d  = step_q + SW'(1);
                                state_d = S_LOAD;
                            end else if (loop_q) begin
                                step_d  = '0;
                                state_d = S_LOAD;
                            end else begin
                                run_d   = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_IDLE;
`ifdef BLINK_SEQ_IRQ_EN
                                if (irq_en_q) begin
                                    irq_d = 1'b1;
                                end
`endif
                            end
                        end else begin
                            ms_cnt_d = ms_cnt_q + 16'd1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d      = (state_d != S_IDLE);
        m_cs_d      = (state_d == S_LOAD);
        m_addr_d    = m_cs_d ? led_d : 2'd0;
        m_wr_data_d = m_cs_d ? tbl_q[{step_d, led_d}] : 16'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            led_q       <= '0;
            step_q      <= '0;
            ms_cnt_q    <= '0;
            run_q       <= 1'b0;
            loop_q      <= 1'b0;
            last_q      <= '0;
            dwell_q     <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            m_cs_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wr_data_q <= '0;
`ifdef BLINK_SEQ_IRQ_EN
            irq_en_q    <= 1'b0;
            irq_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            step_q      <= step_d;
            ms_cnt_q    <= ms_cnt_d;
            run_q       <= run_d;
            loop_q      <= loop_d;
            last_q      <= last_d;
            dwell_q     <= dwell_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            m_cs_q      <= m_cs_d;
            m_addr_q    <= m_addr_d;
            m_wr_data_q <= m_wr_data_d;
`ifdef BLINK_SEQ_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
`endif
        end
    end

    // Host read port is combinational
    always_comb begin
        rd_data = '0;
        if (cs && rd) begin
            if (addr < 6'(ENTRIES)) begin
                rd_data = tbl_q[addr[TW-1:0]];
            end else begin
                unique case (addr)
                    ADDR_CTRL: begin
                        rd_data[CTRL_RUN]           = run_q;
                        rd_data[CTRL_LOOP]          = loop_q;
                        rd_data[CTRL_LAST_LSB +: 3] = last_q;
`ifdef BLINK_SEQ_IRQ_EN
                        rd_data[CTRL_IRQ_EN]        = irq_en_q;
`endif
                    end
                    ADDR_DWELL: rd_data = dwell_q;
                    ADDR_STATUS: begin
                        rd_data[STAT_BUSY]          = busy_q;
                        rd_data[STAT_STEP_LSB +: 3] = 3'(step_q);
                        rd_data[STAT_DONE]          = done_q;
                    end
                    default: rd_data = '0;
                endcase
            end
        end
    end

    assign m_cs      = m_cs_q;
    assign m_we      = m_cs_q;
    assign m_addr    = m_addr_q;
    assign m_wr_data = m_wr_data_q;
    assign busy      = busy_q;
`ifdef BLINK_SEQ_IRQ_EN
    assign irq       = irq_q;
`else
    assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_blink_seq_ctrl.sv
// Directed self-checking bench for blink_seq_ctrl at 10 cycles per ms.
module tb_blink_seq_ctrl;
    import blink_seq_pkg::*;

    localparam int unsigned CLK_FREQ = 10_000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0, we = 1'b0, rd = 1'b0;
    logic [5:0]  addr = '0;
    logic [15:0] wr_data = '0;
    logic [15:0] rd_data;
    logic        m_cs, m_we, busy, irq;
    logic [1:0]  m_addr;
    logic [15:0] m_wr_data;

    logic        cs4 = 1'b0;
    logic [15:0] rd_data4, m_wr_data4;
    logic        m_cs4, m_we4, busy4, irq4;
    logic [1:0]  m_addr4;

    int n_checks = 0;
    int n_errors = 0;
    int wr_count = 0;
    logic [1:0] last_m_addr = '0;

    always #5 clk = ~clk;

    blink_seq_ctrl #(.CLK_FREQ(CLK_FREQ), .STEPS(8)) u_dut (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .m_cs(m_cs), .m_we(m_we),
        .m_addr(m_addr), .m_wr_data(m_wr_data), .busy(busy), .irq(irq)
    );

    blink_seq_ctrl #(.CLK_FREQ(CLK_FREQ), .STEPS(4)) u_dut4 (
        .clk(clk), .rst(rst), .cs(cs4), .we(we), .rd(rd), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data4), .m_cs(m_cs4), .m_we(m_we4),
        .m_addr(m_addr4), .m_wr_data(m_wr_data4), .busy(busy4), .irq(irq4)
    );

    always @(negedge clk) begin
        if (m_cs) begin
            wr_count    = wr_count + 1;
            last_m_addr = m_addr;
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {10'd0, irq, busy, m_cs, m_we, m_addr, m_wr_data};
    endfunction

    function automatic logic [31:0] load_word(input int l, input logic [15:0] v);
        return {10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'(l), v};
    endfunction

    function automatic logic [15:0] exp_val(input int s, input int l);
        return 16'hA000 | 16'(s * 16 + l);
    endfunction

    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [15:0] exp);
        cs = 1'b1; rd = 1'b1; addr = a;
        #1;
        check(tag, 32'(rd_data), 32'(exp));
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_burst(input int s);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("lp_load_s%0d_l%0d", s, l), obs(), load_word(l, exp_val(s, l)));
            @(negedge clk);
        end
    endtask

    int n, wc0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_outputs", obs(), 32'd0);
        rst = 1'b0;
        read_check("rst_status", ADDR_STATUS, 16'h0000);

        // Single step, 2 ms dwell
        for (int l = 0; l < 4; l++) host_write(6'(l), 16'(16'h11 * (l + 1)));
        host_write(ADDR_DWELL, 16'd2);
        host_write(ADDR_CTRL, 16'h0001);
        for (int l = 0; l < 4; l++) begin
            check($sformatf("ss_load%0d", l), obs(), load_word(l, 16'(16'h11 * (l + 1))));
            @(negedge clk);
        end
        wait_idle(n);
        check("ss_dwell_cycles", 32'(n), 32'd20);
        check("ss_idle_outputs", obs(), 32'd0);
        read_check("ss_status", ADDR_STATUS, 16'h0010);
        read_check("ss_ctrl", ADDR_CTRL, 16'h0000);

        // Three-step loop, 1 ms dwell
        for (int s = 0; s < 3; s++)
            for (int l = 0; l < 4; l++) host_write(6'(s * 4 + l), exp_val(s, l));
        host_write(ADDR_DWELL, 16'd1);
        host_write(ADDR_CTRL, 16'h0023);
        for (int k = 0; k < 5; k++) begin
            check_burst(k % 3);
            if (k < 4) begin
                n = 0;
                while (!m_cs && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                check($sformatf("lp_gap%0d", k), 32'(n), 32'd10);
            end
        end
        read_check("lp_status_run", ADDR_STATUS, 16'h0003);
        repeat (3) @(negedge clk);
        host_write(ADDR_CTRL, 16'h0022);
        check("lp_abort_outputs", obs(), 32'd0);
        read_check("lp_abort_status", ADDR_STATUS, 16'h0002);

        // Abort while led 1 is being written
        wc0 = wr_count;
        host_write(ADDR_CTRL, 16'h0001);
        host_write(ADDR_CTRL, 16'h0000);
        check("ab_outputs", obs(), 32'd0);
        repeat (6) @(negedge clk);
        check("ab_write_count", 32'(wr_count - wc0), 32'd2);
        check("ab_last_addr", 32'(last_m_addr), 32'd1);
        read_check("ab_status", ADDR_STATUS, 16'h0000);

        // DWELL=0 behaves as 1 ms
        host_write(ADDR_DWELL, 16'd0);
        host_write(ADDR_CTRL, 16'h0001);
        wait_idle(n);
        check("dw0_busy_cycles", 32'(n), 32'd14);
        read_check("dw0_status", ADDR_STATUS, 16'h0010);

        // Unmapped address
        host_write(6'h23, 16'hFFFF);
        read_check("unmapped_rd", 6'h23, 16'h0000);
        read_check("unmapped_ctrl", ADDR_CTRL, 16'h0000);
        read_check("unmapped_dwell", ADDR_DWELL, 16'h0000);

        // Re-writing run while running
        host_write(ADDR_DWELL, 16'd2);
        wc0 = wr_count;
        host_write(ADDR_CTRL, 16'h0001);
        repeat (8) @(negedge clk);
        host_write(ADDR_CTRL, 16'h0001);
        wait_idle(n);
        check("rr_remaining", 32'(n), 32'd14);
        check("rr_write_count", 32'(wr_count - wc0), 32'd4);

        // last_step clamp
        host_write(ADDR_CTRL, 16'h0070);
        read_check("clamp_steps8", ADDR_CTRL, 16'h0070);
        @(negedge clk);
        cs4 = 1'b1; we = 1'b1; addr = ADDR_CTRL; wr_data = 16'h0070;
        @(negedge clk);
        cs4 = 1'b0; we = 1'b0;
        cs4 = 1'b1; rd = 1'b1; addr = ADDR_CTRL;
        #1;
        check("clamp_steps4", 32'(rd_data4), 32'h0030);
        cs4 = 1'b0; rd = 1'b0;

`ifdef BLINK_SEQ_IRQ_EN
        host_write(ADDR_CTRL, 16'h0081);
        wait_idle(n);
        check("irq_set", 32'(irq), 32'd1);
        read_check("irq_status", ADDR_STATUS, 16'h0010);
        host_write(ADDR_STATUS, 16'h0010);
        check("irq_clear", 32'(irq), 32'd0);
        read_check("irq_done_clear", ADDR_STATUS, 16'h0000);
        host_write(ADDR_CTRL, 16'h0001);
        wait_idle(n);
        check("irq_masked", 32'(irq), 32'd0);
        read_check("irq_masked_done", ADDR_STATUS, 16'h0010);
`else
        host_write(ADDR_CTRL, 16'h0081);
        wait_idle(n);
        check("irq_tied_low", 32'(irq), 32'd0);
        read_check("irq_off_done", ADDR_STATUS, 16'h0010);
        read_check("irq_off_ctrl", ADDR_CTRL, 16'h0000);
`endif

        // Asynchronous reset mid-LOAD
        host_write(ADDR_CTRL, 16'h0001);
        @(negedge clk);
        check("pre_rst_load", 32'(m_cs), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_outputs", obs(), 32'd0);
        read_check("rst_async_status", ADDR_STATUS, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        read_check("rst_ctrl", ADDR_CTRL, 16'h0000);
        read_check("rst_dwell", ADDR_DWELL, 16'h0000);
        read_check("rst_table", 6'h00, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
